// File: rtl/ballot_sender.sv
// ballot_sender
//   Queues ballot requests in a small FIFO and replays them one per cycle as
//   registered one-hot vote pulses. Each voter is counted only once. Repeat
//   ballots and illegal ballots are dropped and counted separately. Asserting
//   close seals the box: no new requests are taken, and done rises once the
//   queue has drained.
// Ports
//   clk, reset (async, active-low)
//   req_valid/req_ready      request handshake (ready is combinational)
//   req_class, req_id        0=np any id, 1=vip id<8, 2=vvip id 0, else illegal
//   close                    level; moves OPEN -> DRAIN
//   np, vip, vvip            one-cycle vote pulses
//   score                    1 per np, 4 per vip, 16 for the vvip voter
//   dup_count, err_count     saturating drop counters
//   done                     sealed and drained
module ballot_sender #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_class,
  input  logic [4:0]  req_id,
  input  logic        close,
  output logic        req_ready,
  output logic [31:0] np,
  output logic [7:0]  vip,
  output logic        vvip,
  output logic [7:0]  score,
  output logic [7:0]  dup_count,
  output logic [7:0]  err_count,
  output logic        done
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {OPEN, DRAIN, SEALED} state_t;

  state_t        state_q, state_d;
  logic [6:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   np_mask_q, np_mask_d;
  logic [7:0]    vip_mask_q, vip_mask_d;
  logic          vvip_mask_q, vvip_mask_d;
  logic [31:0]   np_q, np_d;
  logic [7:0]    vip_q, vip_d;
  logic          vvip_q, vvip_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    dup_q, dup_d;
  logic [7:0]    err_q, err_d;
  logic          done_q, done_d;

  logic          push, pop;
  logic [6:0]    head;
  logic [1:0]    head_class;
  logic [4:0]    head_id;
  logic          is_dup, is_err;

  // Gating with reset keeps ready low for the whole time reset is held.
  assign req_ready = reset && (state_q == OPEN) &&
                     (count_q != (PW+1)'(FIFO_DEPTH));
  assign push = req_valid && req_ready;
  assign pop  = (count_q != '0);

  assign head       = mem_q[rd_ptr_q];
  assign head_class = head[6:5];
  assign head_id    = head[4:0];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    np_mask_d   = np_mask_q;
    vip_mask_d  = vip_mask_q;
    vvip_mask_d = vvip_mask_q;
    np_d        = '0;
    vip_d       = '0;
    vvip_d      = 1'b0;
    score_d     = score_q;
    dup_d       = dup_q;
    err_d       = err_q;
    is_dup      = 1'b0;
    is_err      = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase

    // Classification happens on the way out of the queue.
    if (pop) begin
      case (head_class)
        2'd0: begin
          if (np_mask_q[head_id]) begin
            is_dup = 1'b1;
          end else begin
            np_mask_d[head_id] = 1'b1;
            np_d[head_id]      = 1'b1;
            score_d            = score_q + 8'd1;
          end
        end
        2'd1: begin
          if (head_id[4:3] != 2'b00) begin
            is_err = 1'b1;
          end else if (vip_mask_q[head_id[2:0]]) begin
            is_dup = 1'b1;
          end else begin
            vip_mask_d[head_id[2:0]] = 1'b1;
            vip_d[head_id[2:0]]      = 1'b1;
            score_d                  = score_q + 8'd4;
          end
        end
        2'd2: begin
          if (head_id != 5'd0) begin
            is_err = 1'b1;
          end else if (vvip_mask_q) begin
            is_dup = 1'b1;
          end else begin
            vvip_mask_d = 1'b1;
            vvip_d      = 1'b1;
            score_d     = score_q + 8'd16;
          end
        end
        default: is_err = 1'b1;
      endcase
    end

    if (is_dup && dup_q != 8'hFF) dup_d = dup_q + 8'd1;
    if (is_err && err_q != 8'hFF) err_d = err_q + 8'd1;

    case (state_q)
      OPEN:    if (close) state_d = DRAIN;
      // Seal on an edge that sees an empty queue, i.e. one cycle after the
      // final pop, so the last pulse has already been issued.
      DRAIN:   if (count_q == '0) state_d = SEALED;
      default: state_d = SEALED;
    endcase

    done_d = (state_d == SEALED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {req_class, req_id};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= OPEN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      np_mask_q   <= '0;
      vip_mask_q  <= '0;
      vvip_mask_q <= 1'b0;
      np_q        <= '0;
      vip_q       <= '0;
      vvip_q      <= 1'b0;
      score_q     <= '0;
      dup_q       <= '0;
      err_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      np_mask_q   <= np_mask_d;
      vip_mask_q  <= vip_mask_d;
      vvip_mask_q <= vvip_mask_d;
      np_q        <= np_d;
      vip_q       <= vip_d;
      vvip_q      <= vvip_d;
      score_q     <= score_d;
      dup_q       <= dup_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign np        = np_q;
  assign vip       = vip_q;
  assign vvip      = vvip_q;
  assign score     = score_q;
  assign dup_count = dup_q;
  assign err_count = err_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ballot_sender.sv
// Testbench for ballot_sender: directed scenarios plus a randomized run,
// all checked cycle by cycle against a queue-based reference model.
module tb_ballot_sender;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_class = 2'd0;
  logic [4:0]  req_id = 5'd0;
  logic        close = 1'b0;
  logic        req_ready;
  logic [31:0] np;
  logic [7:0]  vip;
  logic        vvip;
  logic [7:0]  score, dup_count, err_count;
  logic        done;

  ballot_sender #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_class(req_class),
    .req_id(req_id), .close(close), .req_ready(req_ready), .np(np),
    .vip(vip), .vvip(vvip), .score(score), .dup_count(dup_count),
    .err_count(err_count), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue of pending ballots, sets of voters already
  // counted, and a three-phase box status (0 open, 1 draining, 2 sealed).
  logic [6:0]  mq[$];
  int          m_phase;
  bit [31:0]   m_np_sent;
  bit [7:0]    m_vip_sent;
  bit          m_vvip_sent;
  int          m_dup, m_err;
  logic [31:0] e_np;
  logic [7:0]  e_vip;
  logic        e_vvip;

  function automatic void model_reset();
    mq.delete();
    m_phase = 0;
    m_np_sent = '0; m_vip_sent = '0; m_vvip_sent = 1'b0;
    m_dup = 0; m_err = 0;
    e_np = '0; e_vip = '0; e_vvip = 1'b0;
  endfunction

  function automatic int m_score();
    return $countones(m_np_sent) + 4 * $countones(m_vip_sent) + 16 * int'(m_vvip_sent);
  endfunction

  task automatic compare_outputs();
    check("np", np, e_np);
    check("vip", {24'd0, vip}, {24'd0, e_vip});
    check("vvip", {31'd0, vvip}, {31'd0, e_vvip});
    check("score", {24'd0, score}, m_score());
    check("score_max", {31'd0, (score <= 8'd80)}, 32'd1);
    check("dup_count", {24'd0, dup_count}, (m_dup > 255) ? 255 : m_dup);
    check("err_count", {24'd0, err_count}, (m_err > 255) ? 255 : m_err);
    check("done", {31'd0, done}, {31'd0, (m_phase == 2)});
  endtask

  // One clock cycle: called just after a falling edge, drives the inputs,
  // advances the model across the coming rising edge, then compares.
  task automatic step(input logic v, input logic [1:0] cls, input logic [4:0] id,
                      input logic cl);
    logic       ready;
    logic [6:0] e;
    int         occ;
    req_valid = v; req_class = cls; req_id = id; close = cl;
    #1;
    ready = (m_phase == 0) && (mq.size() < DEPTH);
    check("req_ready", {31'd0, req_ready}, {31'd0, ready});
    occ = mq.size();
    e_np = '0; e_vip = '0; e_vvip = 1'b0;
    if (occ > 0) begin
      e = mq.pop_front();
      if (e[6:5] == 2'd0) begin
        if (m_np_sent[e[4:0]]) m_dup++;
        else begin m_np_sent[e[4:0]] = 1'b1; e_np[e[4:0]] = 1'b1; end
      end else if (e[6:5] == 2'd1 && e[4:0] < 5'd8) begin
        if (m_vip_sent[e[2:0]]) m_dup++;
        else begin m_vip_sent[e[2:0]] = 1'b1; e_vip[e[2:0]] = 1'b1; end
      end else if (e[6:5] == 2'd2 && e[4:0] == 5'd0) begin
        if (m_vvip_sent) m_dup++;
        else begin m_vvip_sent = 1'b1; e_vvip = 1'b1; end
      end else begin
        m_err++;
      end
    end
    if (v && ready) mq.push_back({cls, id});
    if (m_phase == 0 && cl) m_phase = 1;
    else if (m_phase == 1 && occ == 0) m_phase = 2;
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'd0, 5'd0, 1'b0);
  endtask

  // Asynchronous reset pulse spanning one rising edge; outputs must clear
  // before any clock edge arrives.
  task automatic do_reset();
    #3;
    reset = 1'b0;
    req_valid = 1'b0; close = 1'b0;
    #1;
    check("rst_np", np, 32'd0);
    check("rst_vip", {24'd0, vip}, 32'd0);
    check("rst_vvip", {31'd0, vvip}, 32'd0);
    check("rst_score", {24'd0, score}, 32'd0);
    check("rst_dup", {24'd0, dup_count}, 32'd0);
    check("rst_err", {24'd0, err_count}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    check("por_ready", {31'd0, req_ready}, 32'd0);
    check("por_np", np, 32'd0);
    check("por_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Single ordinary ballot
    step(1'b1, 2'd0, 5'd5, 1'b0);
    step(1'b0, 2'd0, 5'd0, 1'b0);
    check("s033_np", np, 32'h0000_0020);
    step(1'b0, 2'd0, 5'd0, 1'b0);
    check("s033_np_off", np, 32'd0);
    check("s033_score", {24'd0, score}, 32'd1);
    $display("txn s033 np5 score=%0d", score);

    // Mixed classes with one repeat
    do_reset();
    step(1'b1, 2'd0, 5'd3, 1'b0);
    step(1'b1, 2'd1, 5'd2, 1'b0);
    step(1'b1, 2'd2, 5'd0, 1'b0);
    step(1'b1, 2'd0, 5'd3, 1'b0);
    idle(3);
    check("s034_score", {24'd0, score}, 32'd21);
    check("s034_dup", {24'd0, dup_count}, 32'd1);
    $display("txn s034 score=%0d dup=%0d", score, dup_count);

    // Illegal ballots
    do_reset();
    step(1'b1, 2'd3, 5'd0, 1'b0);
    step(1'b1, 2'd1, 5'd9, 1'b0);
    step(1'b1, 2'd2, 5'd1, 1'b0);
    idle(3);
    check("s035_err", {24'd0, err_count}, 32'd3);
    check("s035_score", {24'd0, score}, 32'd0);
    $display("txn s035 err=%0d score=%0d", err_count, score);

    // Burst of six
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b1, 2'd0, 5'(10 + k), 1'b0);
    idle(3);
    check("s036_score", {24'd0, score}, 32'd6);
    $display("txn s036 burst6 score=%0d", score);

    // Close with traffic, then late requests are refused
    do_reset();
    step(1'b1, 2'd0, 5'd1, 1'b0);
    step(1'b1, 2'd0, 5'd2, 1'b0);
    step(1'b1, 2'd0, 5'd3, 1'b1);
    step(1'b1, 2'd0, 5'd4, 1'b0);
    idle(3);
    step(1'b1, 2'd1, 5'd1, 1'b0);
    idle(2);
    check("s037_done", {31'd0, done}, 32'd1);
    check("s037_score", {24'd0, score}, 32'd3);
    $display("txn s037 done=%0d score=%0d", done, score);

    // Reset with a pulse in flight
    do_reset();
    step(1'b1, 2'd0, 5'd7, 1'b0);
    step(1'b1, 2'd0, 5'd8, 1'b0);
    do_reset();
    idle(4);
    check("s038_score", {24'd0, score}, 32'd0);
    $display("txn s038 score=%0d", score);

    // Randomized traffic
    begin
      int sealed_cycles = 0;
      for (int n = 0; n < 1500; n++) begin
        logic       v, cl;
        logic [1:0] cls;
        logic [4:0] id;
        v   = ($urandom_range(0, 3) != 0);
        cls = 2'($urandom_range(0, 3));
        id  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        cl  = ($urandom_range(0, 149) == 0);
        step(v, cls, id, cl);
        sealed_cycles = (m_phase == 2) ? sealed_cycles + 1 : 0;
        if (sealed_cycles > 5 || $urandom_range(0, 299) == 0) begin
          do_reset();
          sealed_cycles = 0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
